// File: rtl/sram_slot_arbiter.sv
// sram_slot_arbiter: shares one asynchronous SRAM between the CPU, the video
// fetch and an auxiliary master on clk_32m. CPU/video accesses launch in their
// clock-enable slots; idle slots go to the auxiliary master. A strobe that
// cannot launch is remembered in a pend flag. A second strobe that arrives
// while that flag is still set is dropped and counted.
// Optional feature: define SRAM_ARB_AUX_EN to enable the auxiliary port.
module sram_slot_arbiter #(
   parameter int ADDR_W = 19
) (
   input  logic              clk_32m,
   input  logic              reset_n,
   input  logic              cpu_clken,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_we,
   input  logic [7:0]        cpu_wdata,
   output logic [7:0]        cpu_rdata,
   output logic              cpu_valid,
   input  logic              vid_clken,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic [7:0]        vid_rdata,
   output logic              vid_valid,
   input  logic              aux_req,
   input  logic [ADDR_W-1:0] aux_addr,
   input  logic              aux_we,
   input  logic [7:0]        aux_wdata,
   output logic [7:0]        aux_rdata,
   output logic              aux_ack,
   input  logic              drop_clr,
   output logic [7:0]        drop_cnt,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [7:0]        sram_dout,
   output logic              sram_dout_en,
   input  logic [7:0]        sram_din,
   output logic              sram_oe_n,
   output logic              sram_we_n
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, WHOLD} state_t;
   typedef enum logic [1:0] {OWN_CPU, OWN_VID, OWN_AUX} owner_t;

   state_t            state;
   owner_t            owner;
   logic              cpu_pend, vid_pend;
   logic [7:0]        aux_rdata_r;
   logic              aux_ack_r;

   logic              aux_go;
   logic              go_cpu, go_vid, go_aux;
   logic              cpu_drop, vid_drop, cpu_defer, vid_defer;
   logic              launch, l_we;
   owner_t            l_owner;
   logic [ADDR_W-1:0] l_addr;
   logic [7:0]        l_wdata;

   function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] n);
      logic [8:0] s;
      s = {1'b0, a} + {7'b0, n};
      return s[8] ? 8'hFF : s[7:0];
   endfunction

`ifdef SRAM_ARB_AUX_EN
   // An aux request is only taken once its previous access has fully retired
   assign aux_go    = aux_req && !aux_ack_r && !((state != IDLE) && (owner == OWN_AUX));
   assign aux_ack   = aux_ack_r;
   assign aux_rdata = aux_rdata_r;
`else
   logic unused_aux;
   assign unused_aux = ^{aux_req, aux_addr, aux_we, aux_wdata, aux_rdata_r, aux_ack_r};
   assign aux_go     = 1'b0;
   assign aux_ack    = 1'b0;
   assign aux_rdata  = 8'h00;
`endif

   // Launch arbitration: pending slots first, then fresh strobes, then aux
   always_comb begin
      go_cpu  = 1'b0;
      go_vid  = 1'b0;
      go_aux  = 1'b0;
      if (state != WRITE) begin
         if (cpu_pend)       go_cpu = 1'b1;
         else if (vid_pend)  go_vid = 1'b1;
         else if (cpu_clken) go_cpu = 1'b1;
         else if (vid_clken) go_vid = 1'b1;
         else if (aux_go)    go_aux = 1'b1;
      end
      launch  = go_cpu || go_vid || go_aux;
      l_owner = go_cpu ? OWN_CPU : (go_vid ? OWN_VID : OWN_AUX);
      l_we    = go_cpu ? cpu_we : (go_aux ? aux_we : 1'b0);
      l_addr  = go_cpu ? cpu_addr : (go_vid ? vid_addr : aux_addr);
      l_wdata = go_cpu ? cpu_wdata : aux_wdata;
      // The pend flag stands for exactly one outstanding slot, so a repeat strobe is lost
      cpu_drop  = cpu_clken && cpu_pend;
      vid_drop  = vid_clken && vid_pend;
      cpu_defer = cpu_clken && !cpu_pend && !go_cpu;
      vid_defer = vid_clken && !vid_pend && !go_vid;
   end

   // Pend flags: set on a deferred strobe, cleared when the deferred access launches
   always_ff @(posedge clk_32m or negedge reset_n) begin
      if (!reset_n) begin
         cpu_pend <= 1'b0;
         vid_pend <= 1'b0;
      end else begin
         if (cpu_pend && go_cpu) cpu_pend <= 1'b0;
         else if (cpu_defer)     cpu_pend <= 1'b1;
         if (vid_pend && go_vid) vid_pend <= 1'b0;
         else if (vid_defer)     vid_pend <= 1'b1;
      end
   end

   // Dropped-strobe counter; clear beats a simultaneous increment
   always_ff @(posedge clk_32m or negedge reset_n) begin
      if (!reset_n)      drop_cnt <= 8'h00;
      else if (drop_clr) drop_cnt <= 8'h00;
      else               drop_cnt <= sat_add(drop_cnt, {1'b0, cpu_drop} + {1'b0, vid_drop});
   end

   // Access sequencer: completes the current access and launches the next one
   always_ff @(posedge clk_32m or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         owner        <= OWN_CPU;
         sram_addr    <= '0;
         sram_dout    <= 8'h00;
         sram_dout_en <= 1'b0;
         sram_oe_n    <= 1'b1;
         sram_we_n    <= 1'b1;
         cpu_rdata    <= 8'h00;
         cpu_valid    <= 1'b0;
         vid_rdata    <= 8'h00;
         vid_valid    <= 1'b0;
         aux_rdata_r  <= 8'h00;
         aux_ack_r    <= 1'b0;
      end else begin
         cpu_valid <= 1'b0;
         vid_valid <= 1'b0;
         aux_ack_r <= 1'b0;
         if (state == READ) begin
            case (owner)
               OWN_CPU: begin cpu_rdata   <= sram_din; cpu_valid <= 1'b1; end
               OWN_VID: begin vid_rdata   <= sram_din; vid_valid <= 1'b1; end
               default: begin aux_rdata_r <= sram_din; aux_ack_r <= 1'b1; end
            endcase
         end else if (state == WHOLD) begin
            case (owner)
               OWN_CPU: cpu_valid <= 1'b1;
               OWN_VID: vid_valid <= 1'b1;
               default: aux_ack_r <= 1'b1;
            endcase
         end
         if (state == WRITE) begin
            // Release WE but keep address and data on the pins for hold time
            state     <= WHOLD;
            sram_we_n <= 1'b1;
         end else if (launch) begin
            owner     <= l_owner;
            sram_addr <= l_addr;
            if (l_we) begin
               state        <= WRITE;
               sram_dout    <= l_wdata;
               sram_dout_en <= 1'b1;
               sram_we_n    <= 1'b0;
               sram_oe_n    <= 1'b1;
            end else begin
               state        <= READ;
               sram_dout_en <= 1'b0;
               sram_we_n    <= 1'b1;
               sram_oe_n    <= 1'b0;
            end
         end else begin
            state        <= IDLE;
            sram_dout_en <= 1'b0;
            sram_oe_n    <= 1'b1;
            sram_we_n    <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sram_slot_arbiter.sv
// Directed bench for sram_slot_arbiter with a behavioural asynchronous SRAM.
// Unwritten SRAM locations read back as addr[7:0] ^ 8'h91.
module tb_sram_slot_arbiter;

   localparam int ADDR_W = 19;

   logic              clk_32m = 1'b0;
   logic              reset_n = 1'b0;
   logic              cpu_clken = 1'b0;
   logic [ADDR_W-1:0] cpu_addr = '0;
   logic              cpu_we = 1'b0;
   logic [7:0]        cpu_wdata = 8'h00;
   logic [7:0]        cpu_rdata;
   logic              cpu_valid;
   logic              vid_clken = 1'b0;
   logic [ADDR_W-1:0] vid_addr = '0;
   logic [7:0]        vid_rdata;
   logic              vid_valid;
   logic              aux_req = 1'b0;
   logic [ADDR_W-1:0] aux_addr = '0;
   logic              aux_we = 1'b0;
   logic [7:0]        aux_wdata = 8'h00;
   logic [7:0]        aux_rdata;
   logic              aux_ack;
   logic              drop_clr = 1'b0;
   logic [7:0]        drop_cnt;
   logic [ADDR_W-1:0] sram_addr;
   logic [7:0]        sram_dout;
   logic              sram_dout_en;
   logic [7:0]        sram_din = 8'h00;
   logic              sram_oe_n;
   logic              sram_we_n;

   int n_tests = 0;
   int n_fail  = 0;
   int waited;
   logic got_ack;

   logic [7:0] mem [logic [ADDR_W-1:0]];

   sram_slot_arbiter #(.ADDR_W(ADDR_W)) dut (
      .clk_32m(clk_32m), .reset_n(reset_n),
      .cpu_clken(cpu_clken), .cpu_addr(cpu_addr), .cpu_we(cpu_we),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_valid(cpu_valid),
      .vid_clken(vid_clken), .vid_addr(vid_addr), .vid_rdata(vid_rdata),
      .vid_valid(vid_valid),
      .aux_req(aux_req), .aux_addr(aux_addr), .aux_we(aux_we),
      .aux_wdata(aux_wdata), .aux_rdata(aux_rdata), .aux_ack(aux_ack),
      .drop_clr(drop_clr), .drop_cnt(drop_cnt),
      .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_dout_en(sram_dout_en),
      .sram_din(sram_din), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
   );

   always #5 clk_32m = ~clk_32m;

   // SRAM model: acts mid-cycle so the DUT sees settled data at the next rising edge
   always @(negedge clk_32m) begin
      if (!sram_we_n) mem[sram_addr] = sram_dout;
      if (sram_oe_n)                  sram_din = 8'h00;
      else if (mem.exists(sram_addr)) sram_din = mem[sram_addr];
      else                            sram_din = sram_addr[7:0] ^ 8'h91;
   end

   task automatic tick();
      @(posedge clk_32m);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_addr"},   32'(sram_addr), 32'h0);
      chk({tag, "_dout"},   32'(sram_dout), 32'h0);
      chk({tag, "_douten"}, 32'(sram_dout_en), 32'h0);
      chk({tag, "_oe"},     32'(sram_oe_n), 32'h1);
      chk({tag, "_we"},     32'(sram_we_n), 32'h1);
      chk({tag, "_cval"},   32'(cpu_valid), 32'h0);
      chk({tag, "_vval"},   32'(vid_valid), 32'h0);
      chk({tag, "_ack"},    32'(aux_ack), 32'h0);
      chk({tag, "_drop"},   32'(drop_cnt), 32'h0);
      chk({tag, "_crd"},    32'(cpu_rdata), 32'h0);
   endtask

   initial begin
      // Reset state
      tick();
      chk_reset_outputs("rst");
      #2 reset_n = 1'b1;
      tick();

      // Isolated CPU read from 0x01234 (model returns 0xA5)
      cpu_clken = 1'b1; cpu_addr = 19'h01234; cpu_we = 1'b0;
      tick(); cpu_clken = 1'b0;
      chk("rd_oe_low", 32'(sram_oe_n), 32'h0);
      chk("rd_addr", 32'(sram_addr), 32'h01234);
      chk("rd_val_early", 32'(cpu_valid), 32'h0);
      tick();
      chk("rd_valid", 32'(cpu_valid), 32'h1);
      chk("rd_data", 32'(cpu_rdata), 32'hA5);
      chk("rd_oe_high", 32'(sram_oe_n), 32'h1);
      tick();
      chk("rd_valid_pulse", 32'(cpu_valid), 32'h0);

      // CPU write 0x5A to 0x00010, video read of the same address one cycle later
      cpu_clken = 1'b1; cpu_addr = 19'h00010; cpu_we = 1'b1; cpu_wdata = 8'h5A;
      tick(); cpu_clken = 1'b0;
      chk("wr_we_low", 32'(sram_we_n), 32'h0);
      chk("wr_douten", 32'(sram_dout_en), 32'h1);
      chk("wr_dout", 32'(sram_dout), 32'h5A);
      chk("wr_addr", 32'(sram_addr), 32'h00010);
      vid_clken = 1'b1; vid_addr = 19'h00010;
      tick(); vid_clken = 1'b0;
      chk("wh_we_high", 32'(sram_we_n), 32'h1);
      chk("wh_douten", 32'(sram_dout_en), 32'h1);
      chk("wh_cval", 32'(cpu_valid), 32'h0);
      tick();
      chk("wr_cval", 32'(cpu_valid), 32'h1);
      chk("vdef_oe", 32'(sram_oe_n), 32'h0);
      chk("vdef_addr", 32'(sram_addr), 32'h00010);
      chk("vdef_vval_early", 32'(vid_valid), 32'h0);
      tick();
      chk("vdef_vval", 32'(vid_valid), 32'h1);
      chk("vdef_data", 32'(vid_rdata), 32'h5A);
      chk("vdef_drop", 32'(drop_cnt), 32'h0);
      tick();

      // Simultaneous CPU and video strobes: CPU first, video next cycle
      cpu_clken = 1'b1; cpu_addr = 19'h00020; cpu_we = 1'b0;
      vid_clken = 1'b1; vid_addr = 19'h00030;
      tick(); cpu_clken = 1'b0; vid_clken = 1'b0;
      chk("sim_addr_cpu", 32'(sram_addr), 32'h00020);
      tick();
      chk("sim_cval", 32'(cpu_valid), 32'h1);
      chk("sim_cdata", 32'(cpu_rdata), 32'hB1);
      chk("sim_addr_vid", 32'(sram_addr), 32'h00030);
      chk("sim_vval_early", 32'(vid_valid), 32'h0);
      tick();
      chk("sim_vval", 32'(vid_valid), 32'h1);
      chk("sim_vdata", 32'(vid_rdata), 32'hA1);
      chk("sim_cval_pulse", 32'(cpu_valid), 32'h0);
      chk("sim_drop", 32'(drop_cnt), 32'h0);
      tick();

      // Three video strobes around a CPU write: one deferred, one dropped, one direct
      cpu_clken = 1'b1; cpu_addr = 19'h00040; cpu_we = 1'b1; cpu_wdata = 8'h77;
      tick(); cpu_clken = 1'b0;
      vid_clken = 1'b1; vid_addr = 19'h00050;
      tick();
      chk("tri_drop0", 32'(drop_cnt), 32'h0);
      tick();
      chk("tri_drop1", 32'(drop_cnt), 32'h1);
      chk("tri_cval", 32'(cpu_valid), 32'h1);
      tick(); vid_clken = 1'b0;
      chk("tri_vval1", 32'(vid_valid), 32'h1);
      chk("tri_vdata", 32'(vid_rdata), 32'hC1);
      chk("tri_oe_direct", 32'(sram_oe_n), 32'h0);
      tick();
      chk("tri_vval2", 32'(vid_valid), 32'h1);
      chk("tri_drop_hold", 32'(drop_cnt), 32'h1);
      tick();

      // Clear arriving together with a new drop wins over the increment
      cpu_clken = 1'b1; cpu_addr = 19'h00044; cpu_we = 1'b1; cpu_wdata = 8'h11;
      tick(); cpu_clken = 1'b0;
      vid_clken = 1'b1;
      tick();
      drop_clr = 1'b1;
      tick(); vid_clken = 1'b0; drop_clr = 1'b0;
      chk("clr_prio", 32'(drop_cnt), 32'h0);
      tick();
      chk("clr_vval", 32'(vid_valid), 32'h1);
      tick();

`ifdef SRAM_ARB_AUX_EN
      // Aux write to top address while video strobes occupy odd cycles
      aux_req = 1'b1; aux_we = 1'b1; aux_addr = 19'h7FFFF; aux_wdata = 8'h3C;
      vid_addr = 19'h00060;
      got_ack = 1'b0; waited = 0;
      for (int i = 0; i < 8 && !got_ack; i++) begin
         vid_clken = (i % 2) == 1;
         tick();
         waited = i + 1;
         if (aux_ack) got_ack = 1'b1;
      end
      aux_req = 1'b0; vid_clken = 1'b0;
      chk("aux_wr_ack", 32'(got_ack), 32'h1);
      chk("aux_wr_lat_le4", 32'(waited <= 4), 32'h1);
      tick();
      chk("aux_ack_pulse", 32'(aux_ack), 32'h0);
      tick(); tick(); tick();
      // Aux read back of the written location
      aux_req = 1'b1; aux_we = 1'b0;
      got_ack = 1'b0;
      for (int i = 0; i < 6 && !got_ack; i++) begin
         tick();
         if (aux_ack) got_ack = 1'b1;
      end
      aux_req = 1'b0;
      chk("aux_rd_ack", 32'(got_ack), 32'h1);
      chk("aux_rd_data", 32'(aux_rdata), 32'h3C);
      tick(); tick();
`else
      // Without the aux port the request is ignored
      aux_req = 1'b1; aux_we = 1'b0; aux_addr = 19'h00070;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("aux_off_ack", 32'(aux_ack), 32'h0);
         chk("aux_off_oe", 32'(sram_oe_n), 32'h1);
      end
      aux_req = 1'b0;
      chk("aux_off_rdata", 32'(aux_rdata), 32'h0);
      tick();
`endif

      // Continuous CPU write strobes: one drop every two cycles, counter saturates
      cpu_clken = 1'b1; cpu_addr = 19'h00090; cpu_we = 1'b1; cpu_wdata = 8'h42;
      for (int i = 0; i < 600; i++) tick();
      chk("sat_255", 32'(drop_cnt), 32'hFF);
      tick(); tick();
      chk("sat_hold", 32'(drop_cnt), 32'hFF);
      cpu_clken = 1'b0;
      tick(); tick(); tick(); tick();

      // Reset asserted in the middle of a CPU write
      cpu_clken = 1'b1; cpu_addr = 19'h00080; cpu_we = 1'b1; cpu_wdata = 8'h99;
      tick(); cpu_clken = 1'b0;
      chk("mrst_we_low", 32'(sram_we_n), 32'h0);
      #2 reset_n = 1'b0;
      #1;
      chk("mrst_we_async", 32'(sram_we_n), 32'h1);
      chk("mrst_douten_async", 32'(sram_dout_en), 32'h0);
      chk_reset_outputs("mrst");
      tick();
      chk("mrst_cval_a", 32'(cpu_valid), 32'h0);
      #2 reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("mrst_cval_after", 32'(cpu_valid), 32'h0);
         chk("mrst_we_after", 32'(sram_we_n), 32'h1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
